// File: rtl/rem_pkg.sv
// Shared types and constants for the rem arbiter slice.
package rem_pkg;

    localparam int unsigned REM_W   = 3;
    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_RESP
    } state_t;

endpackage

// File: rtl/rem.sv
// Remainder unit on the low two operand bits with a divide-by-zero flag.
module rem
    import rem_pkg::*;
(
    input  logic [REM_W-1:0] numerator,
    input  logic [REM_W-1:0] denominator,
    output logic [REM_W-1:0] remainder,
    output logic             divbyzero
);

    always_comb begin
        divbyzero = (denominator[1:0] == 2'b00);
        // On divide-by-zero the numerator passes through, so bit 2 carries numerator[2].
        if (divbyzero) begin
            remainder = numerator;
        end else begin
            remainder = {1'b0, numerator[1:0] % denominator[1:0]};
        end
    end

endmodule

// File: rtl/rem_arbiter.sv
// Round-robin sharing of one rem unit between two valid/ready requesters,
// with a saturating divide-by-zero event counter.
module rem_arbiter
    import rem_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [REM_W-1:0]   req_numerator0,
    input  logic [REM_W-1:0]   req_numerator1,
    input  logic [REM_W-1:0]   req_denominator0,
    input  logic [REM_W-1:0]   req_denominator1,
    output logic [NUM_REQ-1:0] resp_valid,
    input  logic [NUM_REQ-1:0] resp_ready,
    output logic [REM_W-1:0]   resp_remainder,
    output logic               resp_divbyzero,
    output logic               busy,
    output logic [CNT_W-1:0]   dbz_count
);

    state_t           state;
    logic             last_grant;
    logic             owner;
    logic             winner;
    logic [REM_W-1:0] op_num;
    logic [REM_W-1:0] op_den;
    logic [REM_W-1:0] rem_out;
    logic             rem_dbz;

    rem u_rem (
        .numerator  (op_num),
        .denominator(op_den),
        .remainder  (rem_out),
        .divbyzero  (rem_dbz)
    );

    // On a tie the requester not granted last time wins.
    always_comb begin
        case (req_valid)
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant;
            default: winner = 1'b0;
        endcase
        req_ready = '0;
        if (state == ST_IDLE && !rst && req_valid != '0) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            last_grant     <= 1'b1;
            owner          <= 1'b0;
            op_num         <= '0;
            op_den         <= '0;
            resp_valid     <= '0;
            resp_remainder <= '0;
            resp_divbyzero <= 1'b0;
            busy           <= 1'b0;
            dbz_count      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if ((req_valid & req_ready) != '0) begin
                        owner      <= winner;
                        last_grant <= winner;
                        op_num     <= winner ? req_numerator1 : req_numerator0;
                        op_den     <= winner ? req_denominator1 : req_denominator0;
                        busy       <= 1'b1;
                        state      <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    resp_remainder    <= rem_out;
                    resp_divbyzero    <= rem_dbz;
                    resp_valid[owner] <= 1'b1;
                    if (rem_dbz && dbz_count != '1) begin
                        dbz_count <= dbz_count + CNT_W'(1);
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready[owner]) begin
                        resp_valid <= '0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rem_arbiter.sv
// Directed bench for rem_arbiter: transaction-level reference model plus literal checks.
module tb_rem_arbiter;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = '0;
    logic [1:0] req_ready;
    logic [2:0] req_numerator0 = '0;
    logic [2:0] req_numerator1 = '0;
    logic [2:0] req_denominator0 = '0;
    logic [2:0] req_denominator1 = '0;
    logic [1:0] resp_valid;
    logic [1:0] resp_ready = 2'b11;
    logic [2:0] resp_remainder;
    logic       resp_divbyzero;
    logic       busy;
    logic [CNT_W-1:0] dbz_count;

    int tests = 0;
    int fails = 0;

    rem_arbiter #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_numerator0  (req_numerator0),
        .req_numerator1  (req_numerator1),
        .req_denominator0(req_denominator0),
        .req_denominator1(req_denominator1),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_remainder  (resp_remainder),
        .resp_divbyzero  (resp_divbyzero),
        .busy            (busy),
        .dbz_count       (dbz_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: tracks the one transaction in flight at the level of
    // "free / computing / presenting", its owner and its arithmetic result.
    int         m_phase = 0;
    int         m_owner = 0;
    int         m_last = 1;
    int         m_cnt = 0;
    bit         m_init = 0;
    bit         m_dbz = 0;
    logic [2:0] m_num = '0;
    logic [2:0] m_den = '0;
    logic [2:0] m_rem = '0;
    logic [2:0] m_mask = 3'b111;

    always @(negedge clk) begin : model
        logic [1:0] exp_ready;
        logic [1:0] exp_valid;
        int w;
        if (rst) begin
            if (m_init) chk("req_ready_during_rst", int'(req_ready), 0);
            m_init = 1;
            m_phase = 0;
            m_last = 1;
            m_cnt = 0;
            m_dbz = 0;
            m_rem = '0;
            m_mask = 3'b111;
        end else if (m_init) begin
            w = (req_valid == 2'b10) ? 1 : (req_valid == 2'b11) ? 1 - m_last : 0;
            exp_ready = '0;
            if (m_phase == 0 && req_valid != 2'b00) exp_ready[w] = 1'b1;
            exp_valid = '0;
            if (m_phase == 2) exp_valid[m_owner] = 1'b1;
            chk("model_req_ready", int'(req_ready), int'(exp_ready));
            chk("model_resp_valid", int'(resp_valid), int'(exp_valid));
            chk("model_busy", int'(busy), (m_phase != 0) ? 1 : 0);
            chk("model_dbz_count", int'(dbz_count), m_cnt);
            chk("model_resp_divbyzero", int'(resp_divbyzero), int'(m_dbz));
            chk("model_resp_remainder", int'(resp_remainder & m_mask), int'(m_rem & m_mask));
            case (m_phase)
                0: if (req_valid != 2'b00) begin
                    m_owner = w;
                    m_last = w;
                    m_num = (w == 1) ? req_numerator1 : req_numerator0;
                    m_den = (w == 1) ? req_denominator1 : req_denominator0;
                    m_phase = 1;
                end
                1: begin
                    if (m_den[1:0] == 2'b00) begin
                        m_dbz = 1;
                        m_rem = {m_num[2], 2'b00};
                        m_mask = 3'b100;
                        if (m_cnt < CNT_MAX) m_cnt++;
                    end else begin
                        m_dbz = 0;
                        m_rem = 3'(int'(m_num[1:0]) % int'(m_den[1:0]));
                        m_mask = 3'b011;
                    end
                    m_phase = 2;
                end
                default: if (resp_ready[m_owner]) m_phase = 0;
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input string name);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid != 2'b00) return;
        end
        chk({name, "_resp_timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Accept happens at the next edge; then drain the response with resp_ready high.
    task automatic finish_op(input string name);
        cyc();
        req_valid = 2'b00;
        wait_resp(name);
        cyc();
    endtask

    initial begin
        int acc;
        do_reset();
        @(negedge clk);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_resp_remainder", int'(resp_remainder), 0);
        chk("rst_resp_divbyzero", int'(resp_divbyzero), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dbz_count", int'(dbz_count), 0);

        // Single request: 7 low bits 11 % 10 = 01, two edges to response.
        cyc();
        req_numerator0 = 3'b111; req_denominator0 = 3'b010; req_valid = 2'b01;
        @(negedge clk);
        chk("t1_req_ready", int'(req_ready), 1);
        cyc();
        req_valid = 2'b00;
        @(negedge clk);
        chk("t1_resp_not_yet", int'(resp_valid), 0);
        chk("t1_busy_calc", int'(busy), 1);
        @(negedge clk);
        chk("t1_resp_valid", int'(resp_valid), 1);
        chk("t1_rem", int'(resp_remainder[1:0]), 1);
        chk("t1_dbz", int'(resp_divbyzero), 0);
        chk("t1_cnt", int'(dbz_count), 0);
        cyc();

        // Simultaneous requests after reset.
        do_reset();
        req_numerator0 = 3'b101; req_denominator0 = 3'b011;
        req_numerator1 = 3'b110; req_denominator1 = 3'b001;
        req_valid = 2'b11;
        @(negedge clk);
        chk("t2_tie_grant0", int'(req_ready), 1);
        cyc();
        req_valid = 2'b10;
        wait_resp("t2a");
        chk("t2_owner0", int'(resp_valid), 1);
        chk("t2_rem0", int'(resp_remainder[1:0]), 1);
        cyc();
        @(negedge clk);
        chk("t2_grant1", int'(req_ready), 2);
        cyc();
        req_valid = 2'b00;
        wait_resp("t2b");
        chk("t2_owner1", int'(resp_valid), 2);
        chk("t2_rem1", int'(resp_remainder[1:0]), 0);
        cyc();
        req_valid = 2'b11;
        @(negedge clk);
        chk("t2_next_tie", int'(req_ready), 1);
        finish_op("t2c");

        // Divide by zero.
        req_numerator0 = 3'b110; req_denominator0 = 3'b100; req_valid = 2'b01;
        @(negedge clk);
        chk("t3_cnt_before", int'(dbz_count), 0);
        cyc();
        req_valid = 2'b00;
        wait_resp("t3");
        chk("t3_dbz", int'(resp_divbyzero), 1);
        chk("t3_rem2", int'(resp_remainder[2]), 1);
        chk("t3_cnt_after", int'(dbz_count), 1);
        cyc();

        // Backpressure, with the non-owner's resp_ready toggled and ignored.
        resp_ready = 2'b00;
        req_numerator0 = 3'b011; req_denominator0 = 3'b010; req_valid = 2'b01;
        req_numerator1 = 3'b010; req_denominator1 = 3'b011;
        cyc();
        req_valid = 2'b10;
        wait_resp("t4");
        for (int i = 0; i < 5; i++) begin
            cyc();
            resp_ready = (i == 2) ? 2'b10 : 2'b00;
            @(negedge clk);
            chk("t4_hold_valid", int'(resp_valid), 1);
            chk("t4_hold_rem", int'(resp_remainder[1:0]), 1);
            chk("t4_hold_dbz", int'(resp_divbyzero), 0);
            chk("t4_hold_req_ready", int'(req_ready), 0);
            chk("t4_hold_busy", int'(busy), 1);
        end
        cyc();
        resp_ready = 2'b11;
        cyc();
        @(negedge clk);
        chk("t4_grant1_after", int'(req_ready), 2);
        finish_op("t4b");

        // Reset while in CALC; last grant was requester 0 so a tie would otherwise go to 1.
        req_numerator0 = 3'b101; req_denominator0 = 3'b000; req_valid = 2'b01;
        cyc();
        req_valid = 2'b00;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5_no_resp", int'(resp_valid), 0);
            chk("t5_cnt_clear", int'(dbz_count), 0);
        end
        cyc();
        req_valid = 2'b11;
        @(negedge clk);
        chk("t5_tie_grant0", int'(req_ready), 1);
        finish_op("t5");

        // Saturation over 260 divide-by-zero operations.
        req_numerator0 = 3'b111; req_denominator0 = 3'b100; req_valid = 2'b01;
        acc = 0;
        for (int i = 0; i < 2000 && acc < 260; i++) begin
            @(negedge clk);
            if (req_ready[0]) acc++;
        end
        chk("t6_accepts", acc, 260);
        cyc();
        req_valid = 2'b00;
        repeat (6) cyc();
        @(negedge clk);
        chk("t6_saturated", int'(dbz_count), 255);
        repeat (3) cyc();
        @(negedge clk);
        chk("t6_holds", int'(dbz_count), 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
